// File: rtl/payout_pkg.sv
// Payout package: FSM state encoding, fault code constants and a sizing helper
// shared by the coin payout controller and its timer.
package payout_pkg;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_ITEM_ENC  = 3'd1;
    localparam logic [2:0] ST_COIN_ENC  = 3'd2;
    localparam logic [2:0] ST_GAP_ENC   = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;
    localparam logic [2:0] ST_FAULT_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ITEM  = ST_ITEM_ENC,
        ST_COIN  = ST_COIN_ENC,
        ST_GAP   = ST_GAP_ENC,
        ST_DONE  = ST_DONE_ENC,
        ST_FAULT = ST_FAULT_ENC
    } payout_state_e;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ITEM_TO = 2'b01;
    localparam logic [1:0] FLT_COIN_TO = 2'b10;
    localparam logic [1:0] FLT_SPUR    = 2'b11;

    // Larger of two integers, used to size the shared timer.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter shared by the motor-on timeout and the inter-nickel gap.
// Counts down while enabled and parks at zero; expired is high at zero.
module payout_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count_r;

    // Counter: a load wins, otherwise count down to zero and hold there
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (enable && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/coin_payout_ctrl.sv
// Coin payout controller: takes one payout request per sale (optional item plus
// change in nickels) and runs the item-release and nickel-hopper motors one unit
// at a time, each unit confirmed by its drop sensor, with timeout and sticky fault.
// Optional build macro PAYOUT_RETRY_EN: a unit's first timeout pauses for the gap
// time and restarts that unit; only a second timeout faults.
module coin_payout_ctrl
    import payout_pkg::*;
#(
    parameter int CHG_W       = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int GAP_CYC     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_item,
    input  logic [CHG_W-1:0] req_nickels,
    output logic             item_motor,
    input  logic             item_sense,
    output logic             coin_motor,
    input  logic             coin_sense,
    output logic             busy,
    output logic             done,
    output logic [CHG_W-1:0] remaining,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             clear_fault
);

    localparam int               TMR_W    = $clog2(max_int(TIMEOUT_CYC, GAP_CYC) + 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
    localparam logic [CHG_W-1:0] ZERO_CHG = {CHG_W{1'b0}};

    payout_state_e    state_r, next_state_s;
    logic             item_q_r, coin_q_r;
    logic             item_edge_s, coin_edge_s;
    logic             accept_s;
    logic             item_pend_r;
    logic             retry_ok_s;
    logic             tmr_load_s, tmr_en_s, tmr_expired_s;
    logic [TMR_W-1:0] tmr_load_val_s;
    logic [CHG_W-1:0] remaining_r;
    logic [1:0]       next_code_s;
    logic             req_ready_r, item_motor_r, coin_motor_r, busy_r, done_r, fault_r;
    logic [1:0]       fault_code_r;

    assign item_edge_s = item_sense & ~item_q_r;
    assign coin_edge_s = coin_sense & ~coin_q_r;

    // Sense history: one register stage per sensor for rising-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            item_q_r <= 1'b0;
            coin_q_r <= 1'b0;
        end else begin
            item_q_r <= item_sense;
            coin_q_r <= coin_sense;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and fault-code decode; a stray coin edge outranks everything,
    // and a sensor edge outranks a timeout in the same cycle
    always_comb begin
        next_state_s = state_r;
        next_code_s  = fault_code_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (coin_edge_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FLT_SPUR;
                end else if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (req_item) begin
                        next_state_s = ST_ITEM;
                    end else if (req_nickels != ZERO_CHG) begin
                        next_state_s = ST_COIN;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ITEM: begin
                if (coin_edge_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FLT_SPUR;
                end else if (item_edge_s) begin
                    if (remaining_r != ZERO_CHG) begin
                        next_state_s = ST_COIN;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else if (tmr_expired_s) begin
                    if (retry_ok_s) begin
                        next_state_s = ST_GAP;
                    end else begin
                        next_state_s = ST_FAULT;
                        next_code_s  = FLT_ITEM_TO;
                    end
                end else begin
                    next_state_s = ST_ITEM;
                end
            end
            ST_COIN: begin
                if (coin_edge_s) begin
                    next_state_s = ST_GAP;
                end else if (tmr_expired_s) begin
                    if (retry_ok_s) begin
                        next_state_s = ST_GAP;
                    end else begin
                        next_state_s = ST_FAULT;
                        next_code_s  = FLT_COIN_TO;
                    end
                end else begin
                    next_state_s = ST_COIN;
                end
            end
            ST_GAP: begin
                if (coin_edge_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FLT_SPUR;
                end else if (tmr_expired_s) begin
                    if (item_pend_r) begin
                        next_state_s = ST_ITEM;
                    end else if (remaining_r != ZERO_CHG) begin
                        next_state_s = ST_COIN;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_DONE: begin
                if (coin_edge_s) begin
                    next_state_s = ST_FAULT;
                    next_code_s  = FLT_SPUR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    next_state_s = ST_IDLE;
                    next_code_s  = FLT_NONE;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_code_s  = FLT_NONE;
            end
        endcase
    end

    // Timer control: reload on every state change, run only in motor/gap states
    always_comb begin
        tmr_load_s = (next_state_s != state_r);
        tmr_en_s   = (state_r == ST_ITEM) || (state_r == ST_COIN) || (state_r == ST_GAP);
        if (next_state_s == ST_GAP) begin
            tmr_load_val_s = GAP_LOAD;
        end else begin
            tmr_load_val_s = TO_LOAD;
        end
    end

    payout_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .enable   (tmr_en_s),
        .expired  (tmr_expired_s)
    );

`ifdef PAYOUT_RETRY_EN
    logic retry_r;

    // Retry flag: armed by a unit's first timeout, cleared by a confirmed drop or a new request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_r <= 1'b0;
        end else if (accept_s || (state_r == ST_FAULT)) begin
            retry_r <= 1'b0;
        end else if (((state_r == ST_ITEM) && item_edge_s) ||
                     ((state_r == ST_COIN) && coin_edge_s)) begin
            retry_r <= 1'b0;
        end else if (((state_r == ST_ITEM) || (state_r == ST_COIN)) &&
                     (next_state_s == ST_GAP)) begin
            retry_r <= 1'b1;
        end else begin
            retry_r <= retry_r;
        end
    end

    assign retry_ok_s = ~retry_r;
`else
    assign retry_ok_s = 1'b0;
`endif

    // Request bookkeeping: capture on accept, count nickels down, discard on fault clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining_r <= ZERO_CHG;
            item_pend_r <= 1'b0;
        end else if (accept_s) begin
            remaining_r <= req_nickels;
            item_pend_r <= req_item;
        end else if ((state_r == ST_FAULT) && clear_fault) begin
            remaining_r <= ZERO_CHG;
            item_pend_r <= 1'b0;
        end else begin
            if ((state_r == ST_COIN) && coin_edge_s) begin
                remaining_r <= remaining_r - CHG_W'(1);
            end else begin
                remaining_r <= remaining_r;
            end
            if ((state_r == ST_ITEM) && item_edge_s) begin
                item_pend_r <= 1'b0;
            end else begin
                item_pend_r <= item_pend_r;
            end
        end
    end

    // Output registers decoded from the next state so they track the state register;
    // done follows the single DONE cycle one clock later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_r  <= 1'b1;
            item_motor_r <= 1'b0;
            coin_motor_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            fault_code_r <= FLT_NONE;
        end else begin
            req_ready_r  <= (next_state_s == ST_IDLE);
            item_motor_r <= (next_state_s == ST_ITEM);
            coin_motor_r <= (next_state_s == ST_COIN);
            busy_r       <= (next_state_s != ST_IDLE) && (next_state_s != ST_FAULT);
            done_r       <= (state_r == ST_DONE) && (next_state_s == ST_IDLE);
            fault_r      <= (next_state_s == ST_FAULT);
            fault_code_r <= next_code_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign item_motor = item_motor_r;
    assign coin_motor = coin_motor_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign remaining  = remaining_r;
    assign fault      = fault_r;
    assign fault_code = fault_code_r;

endmodule

// File: tb/tb_coin_payout_ctrl.sv
// Bench for coin_payout_ctrl: a sensor responder answers each motor after a
// programmed number of motor-on cycles (0 = never), and each scenario predicts
// cycle counts and unit counts with plain arithmetic from the payout rules.
module tb_coin_payout_ctrl;

    localparam int CHG_W = 4;
    localparam int T     = 40;
    localparam int G     = 6;

    logic             clock;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_item;
    logic [CHG_W-1:0] req_nickels;
    logic             item_motor;
    logic             item_sense;
    logic             coin_motor;
    logic             coin_sense;
    logic             busy;
    logic             done;
    logic [CHG_W-1:0] remaining;
    logic             fault;
    logic [1:0]       fault_code;
    logic             clear_fault;

    int total = 0;
    int bad   = 0;

    // responder configuration (written by tests) and state (owned by responder)
    int   item_dly = 0;
    int   coin_dly [16];
    int   req_seq  = 0;
    logic coin_spur = 1'b0;
    int   item_cnt = 0;
    int   coin_cnt = 0;
    int   coin_idx = 0;
    int   seen_seq = 0;
    logic item_resp = 1'b0;
    logic coin_resp = 1'b0;

    assign item_sense = item_resp;
    assign coin_sense = coin_resp | coin_spur;

    coin_payout_ctrl #(
        .CHG_W       (CHG_W),
        .TIMEOUT_CYC (T),
        .GAP_CYC     (G)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_item    (req_item),
        .req_nickels (req_nickels),
        .item_motor  (item_motor),
        .item_sense  (item_sense),
        .coin_motor  (coin_motor),
        .coin_sense  (coin_sense),
        .busy        (busy),
        .done        (done),
        .remaining   (remaining),
        .fault       (fault),
        .fault_code  (fault_code),
        .clear_fault (clear_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sensor responder: pulse the sensor on the Nth negedge the motor is seen on
    always @(negedge clock) begin
        if (seen_seq != req_seq) begin
            seen_seq = req_seq;
            coin_idx = 0;
        end
        if (item_motor) begin
            item_cnt++;
            item_resp = (item_dly != 0) && (item_cnt == item_dly);
        end else begin
            item_cnt  = 0;
            item_resp = 1'b0;
        end
        if (coin_motor && (coin_idx < 16)) begin
            coin_cnt++;
            if ((coin_dly[coin_idx] != 0) && (coin_cnt == coin_dly[coin_idx])) begin
                coin_resp = 1'b1;
                coin_idx++;
            end else begin
                coin_resp = 1'b0;
            end
        end else begin
            coin_cnt  = 0;
            coin_resp = 1'b0;
        end
    end

    // Issue one request and watch it until done, fault or the cycle budget.
    // cyc = negedges since the accepting posedge at which done/fault was first seen.
    task automatic run_req(input bit item, input int n, input bit rnd_clear,
                           output int cyc, output int ip, output int cp, output int ov,
                           output int rerr, output bit got_done, output bit got_fault);
        int   prev_rem;
        logic pi, pc;
        @(negedge clock);
        req_item    = item;
        req_nickels = CHG_W'(n);
        req_valid   = 1'b1;
        req_seq++;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_item = 1'b0; req_nickels = '0;
        cyc = 1; ip = 0; cp = 0; ov = 0; rerr = 0;
        got_done = 1'b0; got_fault = 1'b0; pi = 1'b0; pc = 1'b0; prev_rem = n;
        while (cyc < 2000) begin
            if (item_motor && !pi) ip++;
            if (coin_motor && !pc) cp++;
            if (item_motor && coin_motor) ov++;
            if (int'(remaining) != prev_rem) begin
                if (int'(remaining) != prev_rem - 1) rerr++;
                prev_rem = int'(remaining);
            end
            pi = item_motor;
            pc = coin_motor;
            if (done) begin got_done = 1'b1; break; end
            if (fault) begin got_fault = 1'b1; break; end
            clear_fault = rnd_clear ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
            cyc++;
        end
        clear_fault = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        obs = {req_ready, item_motor, coin_motor, busy, done, fault, fault_code, remaining};
        total++;
        if (obs !== 12'b1000_0000_0000) begin
            bad++; $display("FAIL reset_outputs: got %b expected %b", obs, 12'b1000_0000_0000);
        end
        reset_n = 1'b1;
        @(negedge clock);
        obs = {req_ready, item_motor, coin_motor, busy, done, fault, fault_code, remaining};
        total++;
        if (obs !== 12'b1000_0000_0000) begin
            bad++; $display("FAIL post_reset_idle: got %b expected %b", obs, 12'b1000_0000_0000);
        end
    endtask

    task automatic test_basic();
        int cyc, ip, cp, ov, rerr, s;
        bit gd, gf;
        item_dly = 5; coin_dly[0] = 5; coin_dly[1] = 5;
        s = 5 + 2 * (5 + G);
        run_req(1'b1, 2, 1'b0, cyc, ip, cp, ov, rerr, gd, gf);
        total++;
        if (!gd || gf || cyc != s + 2) begin
            bad++; $display("FAIL basic_latency: got done=%0d fault=%0d cyc=%0d expected done at cyc=%0d", gd, gf, cyc, s + 2);
        end
        total++;
        if (ip != 1 || cp != 2 || ov != 0 || rerr != 0) begin
            bad++; $display("FAIL basic_units: got item=%0d coin=%0d overlap=%0d remerr=%0d expected 1 2 0 0", ip, cp, ov, rerr);
        end
        @(negedge clock);
        total++;
        if ({done, req_ready, remaining} !== {1'b0, 1'b1, 4'd0}) begin
            bad++; $display("FAIL basic_after_done: got done=%0d ready=%0d rem=%0d expected 0 1 0", done, req_ready, remaining);
        end
    endtask

    task automatic test_zero_request();
        int cyc, ip, cp, ov, rerr;
        bit gd, gf;
        run_req(1'b0, 0, 1'b0, cyc, ip, cp, ov, rerr, gd, gf);
        total++;
        if (!gd || cyc != 2 || ip != 0 || cp != 0) begin
            bad++; $display("FAIL zero_request: got done=%0d cyc=%0d item=%0d coin=%0d expected 1 2 0 0", gd, cyc, ip, cp);
        end
    endtask

    task automatic test_random();
        int cyc, ip, cp, ov, rerr, s, n;
        bit gd, gf, item;
        for (int k = 0; k < 25; k++) begin
            item     = 1'($urandom_range(0, 1));
            n        = int'($urandom_range(0, 15));
            item_dly = ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(1, T));
            s        = item ? item_dly : 0;
            for (int j = 0; j < 16; j++) begin
                coin_dly[j] = ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(1, T));
                if (j < n) s += coin_dly[j] + G;
            end
            run_req(item, n, 1'b1, cyc, ip, cp, ov, rerr, gd, gf);
            total++;
            if (!gd || gf || cyc != s + 2) begin
                bad++; $display("FAIL random_latency[%0d]: got done=%0d fault=%0d cyc=%0d expected cyc=%0d", k, gd, gf, cyc, s + 2);
            end
            total++;
            if (ip != int'(item) || cp != n || ov != 0 || rerr != 0 || remaining !== 4'd0) begin
                bad++; $display("FAIL random_units[%0d]: got item=%0d coin=%0d ov=%0d remerr=%0d rem=%0d expected %0d %0d 0 0 0",
                                k, ip, cp, ov, rerr, remaining, item, n);
            end
        end
    endtask

    task automatic test_item_timeout();
        int cyc, ip, cp, ov, rerr, exp_cyc, exp_ip;
        bit gd, gf;
        item_dly = 0;
`ifdef PAYOUT_RETRY_EN
        exp_cyc = 2 * T + G + 1; exp_ip = 2;
`else
        exp_cyc = T + 1; exp_ip = 1;
`endif
        run_req(1'b1, 0, 1'b0, cyc, ip, cp, ov, rerr, gd, gf);
        total++;
        if (!gf || cyc != exp_cyc || ip != exp_ip) begin
            bad++; $display("FAIL item_timeout_time: got fault=%0d cyc=%0d tries=%0d expected 1 %0d %0d", gf, cyc, ip, exp_cyc, exp_ip);
        end
        total++;
        if ({fault_code, item_motor, coin_motor, busy, req_ready} !== 6'b01_0000) begin
            bad++; $display("FAIL item_timeout_state: got code=%b im=%0d cm=%0d busy=%0d ready=%0d expected 01 0 0 0 0",
                            fault_code, item_motor, coin_motor, busy, req_ready);
        end
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
        total++;
        if ({req_ready, fault, fault_code, remaining} !== {1'b1, 1'b0, 2'b00, 4'd0}) begin
            bad++; $display("FAIL item_timeout_clear: got ready=%0d fault=%0d code=%b rem=%0d expected 1 0 00 0",
                            req_ready, fault, fault_code, remaining);
        end
    endtask

    task automatic test_coin_timeout();
        int cyc, ip, cp, ov, rerr, exp_cyc, exp_cp;
        bit gd, gf;
        coin_dly[0] = 4; coin_dly[1] = 0; coin_dly[2] = 0;
`ifdef PAYOUT_RETRY_EN
        exp_cyc = 4 + G + T + G + T + 1; exp_cp = 3;
`else
        exp_cyc = 4 + G + T + 1; exp_cp = 2;
`endif
        run_req(1'b0, 3, 1'b0, cyc, ip, cp, ov, rerr, gd, gf);
        total++;
        if (!gf || cyc != exp_cyc || cp != exp_cp) begin
            bad++; $display("FAIL coin_timeout_time: got fault=%0d cyc=%0d runs=%0d expected 1 %0d %0d", gf, cyc, cp, exp_cyc, exp_cp);
        end
        total++;
        if ({fault_code, coin_motor, remaining} !== {2'b10, 1'b0, 4'd2}) begin
            bad++; $display("FAIL coin_timeout_state: got code=%b cm=%0d rem=%0d expected 10 0 2", fault_code, coin_motor, remaining);
        end
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
        total++;
        if ({req_ready, fault, remaining} !== {1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL coin_timeout_clear: got ready=%0d fault=%0d rem=%0d expected 1 0 0", req_ready, fault, remaining);
        end
    endtask

    task automatic test_spurious();
        @(negedge clock);
        coin_spur = 1'b1;
        @(negedge clock);
        coin_spur = 1'b0;
        total++;
        if ({fault, fault_code, req_ready} !== 4'b1110) begin
            bad++; $display("FAIL spur_idle: got fault=%0d code=%b ready=%0d expected 1 11 0", fault, fault_code, req_ready);
        end
        req_valid = 1'b1; req_item = 1'b1; req_nickels = 4'd3;
        repeat (4) @(negedge clock);
        total++;
        if ({fault, busy, item_motor, coin_motor, remaining} !== {1'b1, 3'b000, 4'd0}) begin
            bad++; $display("FAIL spur_req_ignored: got fault=%0d busy=%0d im=%0d cm=%0d rem=%0d expected 1 0 0 0 0",
                            fault, busy, item_motor, coin_motor, remaining);
        end
        req_valid = 1'b0; req_item = 1'b0; req_nickels = '0;
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
        total++;
        if ({req_ready, fault, fault_code} !== 4'b1000) begin
            bad++; $display("FAIL spur_clear: got ready=%0d fault=%0d code=%b expected 1 0 00", req_ready, fault, fault_code);
        end
        // stray coin edge while the item motor runs
        item_dly = 0;
        req_valid = 1'b1; req_item = 1'b1; req_nickels = 4'd2; req_seq++;
        @(negedge clock);
        req_valid = 1'b0; req_item = 1'b0; req_nickels = '0;
        repeat (3) @(negedge clock);
        coin_spur = 1'b1;
        @(negedge clock);
        coin_spur = 1'b0;
        total++;
        if ({fault, fault_code, item_motor, busy} !== 5'b11100) begin
            bad++; $display("FAIL spur_item: got fault=%0d code=%b im=%0d busy=%0d expected 1 11 0 0", fault, fault_code, item_motor, busy);
        end
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
    endtask

    task automatic test_reset_mid_coin();
        coin_dly[0] = 0;
        @(negedge clock);
        req_valid = 1'b1; req_item = 1'b0; req_nickels = 4'd2; req_seq++;
        @(negedge clock);
        req_valid = 1'b0; req_nickels = '0;
        total++;
        if (coin_motor !== 1'b1) begin
            bad++; $display("FAIL midcoin_motor_on: got %0d expected 1", coin_motor);
        end
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({coin_motor, busy} !== 2'b00) begin
            bad++; $display("FAIL midcoin_reset_drop: got cm=%0d busy=%0d expected 0 0", coin_motor, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if ({req_ready, busy, fault, coin_motor, remaining} !== {4'b1000, 4'd0}) begin
            bad++; $display("FAIL midcoin_after_reset: got ready=%0d busy=%0d fault=%0d cm=%0d rem=%0d expected 1 0 0 0 0",
                            req_ready, busy, fault, coin_motor, remaining);
        end
    endtask

    task automatic test_edge_on_timeout();
        int cyc, ip, cp, ov, rerr, s;
        bit gd, gf;
        item_dly = T; coin_dly[0] = T;
        s = T + T + G;
        run_req(1'b1, 1, 1'b0, cyc, ip, cp, ov, rerr, gd, gf);
        total++;
        if (!gd || gf || cyc != s + 2 || ip != 1 || cp != 1) begin
            bad++; $display("FAIL edge_on_timeout: got done=%0d fault=%0d cyc=%0d item=%0d coin=%0d expected 1 0 %0d 1 1",
                            gd, gf, cyc, ip, cp, s + 2);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_item = 1'b0; req_nickels = '0; clear_fault = 1'b0;
        for (int j = 0; j < 16; j++) coin_dly[j] = 1;
        test_reset();
        test_basic();
        test_zero_request();
        test_random();
        test_item_timeout();
        test_coin_timeout();
        test_spurious();
        test_reset_mid_coin();
        test_edge_on_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
